led_game_ctrl: RTL
==================

Name: led_game_ctrl

Overview:
- Sequencer for the 8-position LED display. It sweeps a lit position back and forth across areas 0..7 at a fixed tick rate and scores player button presses against a target area.
- Drives the display's area, switch and finish inputs and declares a win or a loss.
- Sits between the board push-buttons and the LED display block. It is the only source of area, switch and finish for that block.

Parameters:
- TICK_DIV, 25000000, clk cycles per sweep step; legal range 2 or more.
- TARGET, 7, area index (0..7) that counts as a hit.
- WIN_HITS, 4, hits needed to win; legal range 1..15.
- MAX_MISS, 3, misses that end the game in a loss; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  game start request, synchronous level; acted on at its rising edge.
- btn  in  1  player press, synchronous level; acted on at its rising edge.
- area  out  3  current lit position, feeds the display's area input.
- switch  out  1  display update enable; 1 only in RUN.
- finish  out  1  win indication, feeds the display's finish input; 1 only in WIN.
- lose  out  1  loss indication; 1 only in LOSE.
- score  out  4  hits in the current game.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; area=0; switch=0; finish=0; lose=0; score=0; miss count=0; tick counter=0; dir=up; armed=1; start_d=0; btn_d=0. All outputs are registered.
- Edge detection: start_d and btn_d are registered copies of the inputs. start_rise = start & ~start_d. press = btn & ~btn_d. Both are evaluated in the same cycle they occur.
- States: IDLE, RUN, WIN, LOSE.
- IDLE, WIN, LOSE with start_rise: enter RUN at the next edge. On entry, clear score, miss count, tick counter and lose/finish; set area=0, dir=up, armed=1.
- RUN with start_rise: ignored.
- Tick generation in RUN:
  - The tick counter counts 0..TICK_DIV-1. tick=1 in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
  - The first area advance occurs TICK_DIV cycles after RUN entry.
  - The counter holds at 0 outside RUN.
- Sweep on tick, ping-pong: area sequence is 0,1,..,7,6,..,0,1,...
  - dir flips to down when area advances to 7, and flips to up when area advances to 0. Neither end value repeats.
  - Each tick sets armed=1.
- Press in RUN with armed=1:
  - Compare against the area value registered in that cycle, i.e. the pre-tick value if a tick coincides.
  - area==TARGET is a hit: score+1. Otherwise it is a miss: miss count+1.
  - armed=0 at the same edge. The score or miss update is visible one edge after the press cycle.
- Press with armed=0, or outside RUN: ignored, with no score or miss change.
- Press and tick in the same cycle: the press is scored against the old area. The tick then advances area and re-arms (armed=1 wins over the press clearing it).
- Win: a hit that makes score==WIN_HITS moves the state to WIN at that same edge. finish=1, switch=0, area frozen, score held.
- Loss: a miss that makes miss count==MAX_MISS moves the state to LOSE at that edge. lose=1, switch=0, area frozen, score held.
- Terminal states: WIN and LOSE persist until start_rise or reset.
- Reset mid-game: asserting reset at any time returns immediately to the reset values, with no partial score retained.

Test Plan:
- Reset check: TICK_DIV=4. Assert reset=0 mid-RUN -> area=0, switch=0, finish=0, lose=0, score=0 immediately. After release, the block stays IDLE with no sweep.
- Sweep order and timing: start pulse, no btn -> switch=1. area steps every 4 clk: 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1.
- Hit to win: TARGET=7, WIN_HITS=2. Press once in each of two windows where area=7 -> score 1 then 2. On the second hit, finish=1 and switch=0 at the same edge. area stays 7 afterwards and further presses leave score=2.
- Loss: MAX_MISS=3. Press once while area=2, area=3 and area=4 (in separate steps) -> lose=1 and switch=0 after the third miss, score=0.
- Arming and coincidence:
  - Two presses within one step at area=7 -> score+1 only.
  - A press in the tick cycle while area=7 (advancing to 6) -> counts as a hit. A second press at area=6 -> counts as a miss.
- Restart: start pulse in WIN -> RUN with score=0, lose=0, finish=0, area=0, first advance after 4 clk. A start pulse during RUN -> no effect.

Source files
------------

// File: rtl/led_game_ctrl.sv
// -----------------------------------------------------------------------------
// led_game_ctrl
//
// Game sequencer for the 8-position LED display. While a game is running it
// sweeps a lit position back and forth across areas 0..7, one step every
// TICK_DIV clocks. It scores rising edges of the player button against a
// target area, and it ends the game in a win or a loss.
//
// Ports
//   clk     in   1  system clock
//   reset   in   1  asynchronous, active-low reset
//   start   in   1  game start request, acted on at its rising edge
//   btn     in   1  player press, acted on at its rising edge
//   area    out  3  current lit position, drives the display's area input
//   switch  out  1  display update enable, high only while running
//   finish  out  1  win indication, drives the display's finish input
//   lose    out  1  loss indication
//   score   out  4  hits in the current game
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module led_game_ctrl #(
  parameter int TICK_DIV = 25000000,  // clk cycles per sweep step, >= 2
  parameter int TARGET   = 7,         // area index that counts as a hit
  parameter int WIN_HITS = 4,         // hits needed to win, 1..15
  parameter int MAX_MISS = 3          // misses that lose the game, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn,
  output logic [2:0] area,
  output logic       switch,
  output logic       finish,
  output logic       lose,
  output logic [3:0] score
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [2:0]    TARGET_A   = 3'(TARGET);
  localparam logic [3:0]    WIN_LIMIT  = 4'(WIN_HITS);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WIN,
    LOSE
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // State and datapath registers
  state_t        state;
  dir_t          dir;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    miss_cnt;
  logic          armed;
  logic          start_d;
  logic          btn_d;

  // Next-state values
  state_t        state_nx;
  dir_t          dir_nx;
  logic [CW-1:0] tick_cnt_nx;
  logic [3:0]    miss_cnt_nx;
  logic [3:0]    score_nx;
  logic [2:0]    area_nx;
  logic          armed_nx;
  logic          switch_nx;
  logic          finish_nx;
  logic          lose_nx;

  // Decoded events for the current cycle
  logic start_rise;
  logic press;
  logic tick;
  logic scored;
  logic hit;
  logic won;
  logic lost;

  assign start_rise = start & ~start_d;
  assign press      = btn & ~btn_d;
  assign tick       = (state == RUN) && (tick_cnt == TICK_LAST);
  // A press counts once per sweep step. The armed flag is cleared by the
  // scored press and set again by the next tick.
  assign scored     = (state == RUN) && press && armed;
  assign hit        = scored && (area == TARGET_A);
  assign won        = hit && ((score + 4'd1) == WIN_LIMIT);
  assign lost       = scored && !hit && ((miss_cnt + 4'd1) == MISS_LIMIT);

  // ---------------------------------------------------------------------------
  // State register and all datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples its pre-edge value and edge ordering cannot matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      tick_cnt <= '0;
      miss_cnt <= '0;
      armed    <= 1'b1;
      start_d  <= 1'b0;
      btn_d    <= 1'b0;
      area     <= '0;
      switch   <= 1'b0;
      finish   <= 1'b0;
      lose     <= 1'b0;
      score    <= '0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      tick_cnt <= tick_cnt_nx;
      miss_cnt <= miss_cnt_nx;
      armed    <= armed_nx;
      start_d  <= start;
      btn_d    <= btn;
      area     <= area_nx;
      switch   <= switch_nx;
      finish   <= finish_nx;
      lose     <= lose_nx;
      score    <= score_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a hold value before the case statement, so no
  // path through this block leaves an output unassigned and no latch is built.
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    tick_cnt_nx = tick_cnt;
    miss_cnt_nx = miss_cnt;
    armed_nx    = armed;
    area_nx     = area;
    switch_nx   = switch;
    finish_nx   = finish;
    lose_nx     = lose;
    score_nx    = score;

    case (state)
      IDLE, WIN, LOSE: begin
        // The tick counter holds at zero outside RUN. Area and score stay
        // frozen until a new game starts.
        tick_cnt_nx = '0;
        if (start_rise) begin
          state_nx    = RUN;
          dir_nx      = DIR_UP;
          miss_cnt_nx = '0;
          armed_nx    = 1'b1;
          area_nx     = '0;
          switch_nx   = 1'b1;
          finish_nx   = 1'b0;
          lose_nx     = 1'b0;
          score_nx    = '0;
        end
      end

      RUN: begin
        tick_cnt_nx = tick ? '0 : tick_cnt + CW'(1);

        // Presses are scored against the area shown in this cycle, before
        // any tick in the same cycle moves it.
        if (scored) begin
          armed_nx = 1'b0;
          if (hit) begin
            score_nx = score + 4'd1;
          end else begin
            miss_cnt_nx = miss_cnt + 4'd1;
          end
        end

        // Ping-pong sweep. The direction turns on arrival at an end, so
        // neither 0 nor 7 is shown twice in a row. The tick re-arms even when
        // a press in the same cycle has just disarmed.
        if (tick) begin
          armed_nx = 1'b1;
          if (dir == DIR_UP) begin
            area_nx = area + 3'd1;
            if (area == 3'd6) dir_nx = DIR_DOWN;
          end else begin
            area_nx = area - 3'd1;
            if (area == 3'd1) dir_nx = DIR_UP;
          end
        end

        // Game over freezes the display where the deciding press was made.
        if (won) begin
          state_nx    = WIN;
          area_nx     = area;
          dir_nx      = dir;
          tick_cnt_nx = '0;
          switch_nx   = 1'b0;
          finish_nx   = 1'b1;
        end else if (lost) begin
          state_nx    = LOSE;
          area_nx     = area;
          dir_nx      = dir;
          tick_cnt_nx = '0;
          switch_nx   = 1'b0;
          lose_nx     = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
